ram_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus: consumes address, write-select and write data from the CPU; returns read data one cycle later; drives io_buffer_full.
- Contains 2^ADDR_WIDTH bytes of RAM.
- Decodes the I/O window: UART TX byte queue, UART RX byte input, cycle counter and program-stop register.
- Sits at the top level beside the cpu core, between it and the UART.

---
 rtl/ram_io_responder.sv | 84 ++++++++
 tb/tb_ram_io_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// ram_io_responder: CPU byte-bus responder with RAM, TX FIFO, RX input, cycle counter and halt; ports: clk_in/rst_in, cpu_* bus, tx_* FIFO out, rx_* byte in, halt/tx_overflow flags
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH = 16,
  parameter int FULL_MARGIN = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_rdy,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt,
  output logic        tx_overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] fifo [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_n;
  logic [31:0] cnt, snap;
  logic [2:0] off;
  logic [7:0] rd_data;
  logic is_io, is_ram, rd_acc, wr_acc, push, pop, accept;
  logic unused;
  assign unused = ^cpu_a[31:18];
  always_comb begin
    off = cpu_a[2:0];
    is_io = cpu_a[17:16] == 2'b11;
    is_ram = !cpu_a[17];
    rd_acc = cpu_rdy & !cpu_wr;
    wr_acc = cpu_rdy & cpu_wr;
    push = wr_acc & is_io & (off == 3'd4 | (off == 3'd0 & cpu_din != 8'h00));
    pop = tx_valid & tx_ready;
    accept = push & (!count[PW] | pop);
    count_n = count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
    rd_data = is_ram ? mem[cpu_a[ADDR_WIDTH-1:0]] :
              !is_io ? 8'h00 :
              off == 3'd0 ? (rx_valid ? rx_data : 8'h00) :
              off == 3'd4 ? cnt[7:0] :
              off == 3'd5 ? snap[15:8] :
              off == 3'd6 ? snap[23:16] :
              off == 3'd7 ? snap[31:24] : 8'h00;
  end
  assign tx_valid = count != '0;
  assign tx_data = tx_valid ? fifo[rd_ptr] : 8'h00;
  assign rx_ready = !rst_in & rd_acc & is_io & off == 3'd0 & rx_valid;
  always_ff @(posedge clk_in) begin
    if (!rst_in & wr_acc & is_ram) mem[cpu_a[ADDR_WIDTH-1:0]] <= cpu_din;
    if (!rst_in & accept) fifo[wr_ptr] <= cpu_a[2] ? 8'h00 : cpu_din;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cpu_dout <= 8'h00;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow <= 1'b0;
      halt <= 1'b0;
      cnt <= '0;
      snap <= '0;
    end else begin
      count <= count_n;
      wr_ptr <= wr_ptr + PW'(accept);
      rd_ptr <= rd_ptr + PW'(pop);
      io_buffer_full <= count_n >= (PW+1)'(TX_DEPTH - FULL_MARGIN);
      tx_overflow <= tx_overflow | (push & count[PW] & !pop);
      halt <= halt | (wr_acc & is_io & off == 3'd4);
      cnt <= halt ? cnt : cnt + 32'd1;
      if (rd_acc) cpu_dout <= rd_data;
      if (rd_acc & is_io & off == 3'd4) snap <= cnt;
    end
  end
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: table-driven and directed checks of ram_io_responder
module tb_ram_io_responder;
  logic clk_in = 1'b0, rst_in = 1'b1, cpu_rdy = 1'b0, cpu_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0] cpu_din = '0, rx_data = '0;
  logic [7:0] cpu_dout, tx_data;
  logic io_buffer_full, tx_valid, rx_ready, halt, tx_overflow;
  int nvec = 0, nerr = 0;
  ram_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_rdy(cpu_rdy), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .halt(halt), .tx_overflow(tx_overflow)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic rdy, wr; logic [31:0] a; logic [7:0] din; logic txr, rxv; logic [7:0] rxd;
    logic rxr; logic [7:0] dout; logic txv; logic [7:0] txd; logic full, ovf, hlt;
  } vec_t;
  vec_t v [18];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    cpu_rdy = r; cpu_wr = w; cpu_a = a; cpu_din = d;
  endtask
  task automatic step;
    @(posedge clk_in); #1;
  endtask
  task automatic do_reset;
    rst_in = 1'b1;
    step;
    chk("rst cpu_dout", cpu_dout, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst halt", halt, 1'b0);
    rst_in = 1'b0;
  endtask
  initial begin
    int n;
    logic [7:0] last;
    v[0]  = '{1'b1,1'b1,32'h00010,8'hA5,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[1]  = '{1'b1,1'b0,32'h00010,8'h00,1'b0,1'b0,8'h00, 1'b0,8'hA5,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[2]  = '{1'b0,1'b0,32'h20004,8'h00,1'b0,1'b0,8'h00, 1'b0,8'hA5,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[3]  = '{1'b1,1'b0,32'h20004,8'h00,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[4]  = '{1'b1,1'b1,32'h30000,8'h41,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b1,8'h41,1'b0,1'b0,1'b0};
    v[5]  = '{1'b1,1'b1,32'h30000,8'h00,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b1,8'h41,1'b0,1'b0,1'b0};
    v[6]  = '{1'b1,1'b1,32'h30000,8'h42,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b1,8'h41,1'b0,1'b0,1'b0};
    v[7]  = '{1'b0,1'b0,32'h00000,8'h00,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b1,8'h42,1'b0,1'b0,1'b0};
    v[8]  = '{1'b0,1'b0,32'h00000,8'h00,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[9]  = '{1'b1,1'b0,32'h30000,8'h00,1'b0,1'b1,8'h37, 1'b1,8'h37,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[10] = '{1'b0,1'b0,32'h30000,8'h00,1'b0,1'b1,8'h37, 1'b0,8'h37,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[11] = '{1'b1,1'b0,32'h30000,8'h00,1'b0,1'b0,8'h37, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[12] = '{1'b1,1'b0,32'h30001,8'h00,1'b0,1'b1,8'h37, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[13] = '{1'b1,1'b1,32'h30001,8'h55,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[14] = '{1'b1,1'b1,32'h00000,8'h11,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[15] = '{1'b1,1'b1,32'h20000,8'h77,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[16] = '{1'b1,1'b0,32'h00000,8'h00,1'b0,1'b0,8'h00, 1'b0,8'h11,1'b0,8'h00,1'b0,1'b0,1'b0};
    v[17] = '{1'b1,1'b0,32'h00010,8'h00,1'b0,1'b0,8'h00, 1'b0,8'hA5,1'b0,8'h00,1'b0,1'b0,1'b0};
    bus(1'b1, 1'b0, 32'h30000, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h99;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst rx_ready", rx_ready, 1'b0);
    chk("rst cpu_dout", cpu_dout, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst full", io_buffer_full, 1'b0);
    chk("rst overflow", tx_overflow, 1'b0);
    chk("rst halt", halt, 1'b0);
    bus(1'b0, 1'b0, 32'h0, 8'h00); rx_valid = 1'b0;
    rst_in = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus(v[i].rdy, v[i].wr, v[i].a, v[i].din);
      tx_ready = v[i].txr; rx_valid = v[i].rxv; rx_data = v[i].rxd;
      #1;
      chk($sformatf("v%0d rx_ready", i), rx_ready, v[i].rxr);
      step;
      chk($sformatf("v%0d cpu_dout", i), cpu_dout, v[i].dout);
      chk($sformatf("v%0d tx_valid", i), tx_valid, v[i].txv);
      chk($sformatf("v%0d tx_data", i), tx_data, v[i].txd);
      chk($sformatf("v%0d full", i), io_buffer_full, v[i].full);
      chk($sformatf("v%0d overflow", i), tx_overflow, v[i].ovf);
      chk($sformatf("v%0d halt", i), halt, v[i].hlt);
    end
    bus(1'b0, 1'b0, 32'h0, 8'h00); tx_ready = 1'b0; rx_valid = 1'b0;
    do_reset;
    for (int i = 1; i <= 16; i++) begin
      bus(1'b1, 1'b1, 32'h30000, 8'h55);
      step;
      if (i == 13) chk("bp full after 13", io_buffer_full, 1'b0);
      if (i == 14) chk("bp full after 14", io_buffer_full, 1'b1);
    end
    chk("bp overflow after 16", tx_overflow, 1'b0);
    tx_ready = 1'b1;
    bus(1'b1, 1'b1, 32'h30000, 8'h66);
    step;
    chk("full push+pop overflow", tx_overflow, 1'b0);
    chk("full push+pop full", io_buffer_full, 1'b1);
    tx_ready = 1'b0;
    bus(1'b1, 1'b1, 32'h30000, 8'h77);
    step;
    chk("bp overflow after drop", tx_overflow, 1'b1);
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    tx_ready = 1'b1;
    n = 0; last = 8'h00;
    for (int k = 0; k < 40 && tx_valid; k++) begin
      last = tx_data; n++;
      step;
    end
    chk("drain count", n, 16);
    chk("drain last byte", last, 8'h66);
    chk("drain full", io_buffer_full, 1'b0);
    tx_ready = 1'b0;
    do_reset;
    repeat (511) step;
    bus(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("cnt byte0", cpu_dout, 8'hFF);
    bus(1'b1, 1'b0, 32'h30005, 8'h00); step;
    chk("cnt byte1", cpu_dout, 8'h01);
    bus(1'b1, 1'b0, 32'h30006, 8'h00); step;
    chk("cnt byte2", cpu_dout, 8'h00);
    bus(1'b1, 1'b0, 32'h30007, 8'h00); step;
    chk("cnt byte3", cpu_dout, 8'h00);
    bus(1'b1, 1'b1, 32'h30004, 8'h5A); step;
    chk("stop halt", halt, 1'b1);
    chk("stop tx_valid", tx_valid, 1'b1);
    chk("stop tx_data", tx_data, 8'h00);
    bus(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("frozen byte0 a", cpu_dout, 8'h04);
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    repeat (5) step;
    bus(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("frozen byte0 b", cpu_dout, 8'h04);
    bus(1'b1, 1'b0, 32'h30005, 8'h00); step;
    chk("frozen byte1", cpu_dout, 8'h02);
    bus(1'b1, 1'b0, 32'h30000, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h5A;
    #1;
    chk("pre-reset rx_ready", rx_ready, 1'b1);
    #1;
    rst_in = 1'b1;
    #1;
    chk("async rx_ready", rx_ready, 1'b0);
    chk("async halt", halt, 1'b0);
    chk("async tx_valid", tx_valid, 1'b0);
    chk("async cpu_dout", cpu_dout, 8'h00);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    rx_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h30004, 8'h00); step;
    chk("post-reset counter", cpu_dout, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
